// File: rtl/vga_pkg.sv
// Shared types and standard mode timings for the VGA timing generator.
// The per-axis quadruples are active / front porch / sync / back porch.
package vga_pkg;

    typedef struct packed {
        logic hSync;
        logic vSync;
        logic valid;
    } vga_sig_t;

    localparam int VGA_640x480_60_H_AV  = 640;
    localparam int VGA_640x480_60_H_FP  = 16;
    localparam int VGA_640x480_60_H_SP  = 96;
    localparam int VGA_640x480_60_H_BP  = 48;
    localparam int VGA_640x480_60_V_AV  = 480;
    localparam int VGA_640x480_60_V_FP  = 10;
    localparam int VGA_640x480_60_V_SP  = 2;
    localparam int VGA_640x480_60_V_BP  = 33;
    localparam bit VGA_640x480_60_H_POL = 1'b0;
    localparam bit VGA_640x480_60_V_POL = 1'b0;

    localparam int SVGA_800x600_60_H_AV  = 800;
    localparam int SVGA_800x600_60_H_FP  = 40;
    localparam int SVGA_800x600_60_H_SP  = 128;
    localparam int SVGA_800x600_60_H_BP  = 88;
    localparam int SVGA_800x600_60_V_AV  = 600;
    localparam int SVGA_800x600_60_V_FP  = 1;
    localparam int SVGA_800x600_60_V_SP  = 4;
    localparam int SVGA_800x600_60_V_BP  = 23;
    localparam bit SVGA_800x600_60_H_POL = 1'b1;
    localparam bit SVGA_800x600_60_V_POL = 1'b1;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator (master) and the
// pixel-generation logic (slave); the slave supplies the pixel enable.
interface vga_timing_gen_if #(
    parameter int CW   = 10,
    parameter int FC_W = 8
);
    logic            pixEn;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic            hSync;
    logic            vSync;
    logic            valid;
    logic            lineStart;
    logic            frameStart;
    logic [FC_W-1:0] frameCount;

    modport master (
        input  pixEn,
        output x, y, hSync, vSync, valid, lineStart, frameStart, frameCount
    );

    modport slave (
        output pixEn,
        input  x, y, hSync, vSync, valid, lineStart, frameStart, frameCount
    );
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that delays the sync/valid bundle by LAT
// pixels so it lines up with downstream pixel-lookup latency.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int       LAT     = 2,
    parameter vga_sig_t RST_VAL = '0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  vga_sig_t din,
    output vga_sig_t dout
);

    if (LAT == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign dout = din;
    end else begin : g_shift
        vga_sig_t stage_q [LAT];
        vga_sig_t stage_d [LAT];

        always_comb begin
            for (int i = 0; i < LAT; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < LAT; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        // Reset flushes every stage so no partial sync pulse escapes.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < LAT; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[LAT-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: x/y counters, sync/valid decode with a
// programmable pipeline delay, line/frame strobes and a frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CW    = 10,
    parameter int H_AV  = 640,
    parameter int H_FP  = 16,
    parameter int H_SP  = 96,
    parameter int H_BP  = 48,
    parameter int V_AV  = 480,
    parameter int V_FP  = 10,
    parameter int V_SP  = 2,
    parameter int V_BP  = 33,
    parameter bit H_POL = 1'b0,
    parameter bit V_POL = 1'b0,
    parameter int LAT   = 2,
    parameter int FC_W  = 8
) (
    input logic              pixClk,
    input logic              reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_AV + H_FP + H_SP + H_BP;
    localparam int V_TOTAL = V_AV + V_FP + V_SP + V_BP;

    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW) || LAT < 0 || LAT > 15 ||
        H_FP == 0 || H_SP == 0 || H_BP == 0 ||
        V_FP == 0 || V_SP == 0 || V_BP == 0) begin : g_bad_params
        $fatal(1, "vga_timing_gen: illegal timing parameters");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_AV);
    localparam logic [CW-1:0] V_ACT    = CW'(V_AV);
    localparam logic [CW-1:0] HS_BEGIN = CW'(H_AV + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_AV + H_FP + H_SP);
    localparam logic [CW-1:0] VS_BEGIN = CW'(V_AV + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_AV + V_FP + V_SP);

    localparam vga_sig_t SIG_IDLE = '{hSync: ~H_POL, vSync: ~V_POL, valid: 1'b0};

    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic            x_wrap, y_wrap;
    logic            line_start;
    vga_sig_t        sig_raw, sig_dly;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        fc_d   = fc_q;
        x_wrap = (x_q == H_LAST);
        y_wrap = (y_q == V_LAST);
        if (vga.pixEn) begin
            x_d = x_wrap ? '0 : x_q + CW'(1);
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + CW'(1);
                if (y_wrap) begin
                    fc_d = fc_q + FC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pixClk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            fc_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
        end
    end

    // vSync decodes from y alone, so it flips on the same edge x wraps.
    always_comb begin
        sig_raw.hSync = (x_q >= HS_BEGIN && x_q < HS_END) ? H_POL : ~H_POL;
        sig_raw.vSync = (y_q >= VS_BEGIN && y_q < VS_END) ? V_POL : ~V_POL;
        sig_raw.valid = (x_q < H_ACT) && (y_q < V_ACT);
    end

    vga_delay_line #(
        .LAT     (LAT),
        .RST_VAL (SIG_IDLE)
    ) u_delay (
        .clk  (pixClk),
        .rst  (reset),
        .en   (vga.pixEn),
        .din  (sig_raw),
        .dout (sig_dly)
    );

    assign line_start     = vga.pixEn && (x_q == '0);
    assign vga.x          = x_q;
    assign vga.y          = y_q;
    assign vga.hSync      = sig_dly.hSync;
    assign vga.vSync      = sig_dly.vSync;
    assign vga.valid      = sig_dly.valid;
    assign vga.lineStart  = line_start;
    assign vga.frameStart = line_start && (y_q == '0);
    assign vga.frameCount = fc_q;

endmodule
